// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and imem write port of the boot loader, plus its status lines.
// The loader takes the slave side; the stream source / memory model takes master.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Receives a length-prefixed, XOR-checksummed byte frame, writes its 32-bit words
// to consecutive imem addresses and releases the processor only on a good load.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    imem_boot_loader_if.slave bus
);
    typedef enum logic [2:0] {LEN0, LEN1, WORD, WRITE, CSUM, DONE, ERR} state_t;

    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

    state_t                state_reg, state_next;
    logic [15:0]           len_reg, len_next;
    logic [ADDR_WIDTH:0]   idx_reg, idx_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    logic [31:0]           word_reg, word_next;
    logic [7:0]            xor_reg, xor_next;
    logic                  rx_ready_reg, rx_ready_next;
    logic                  imem_we_reg, imem_we_next;
    logic [ADDR_WIDTH-1:0] imem_addr_reg, imem_addr_next;
    logic [31:0]           imem_wdata_reg, imem_wdata_next;
    logic                  cpu_reset_reg, cpu_reset_next;
    logic                  done_reg, done_next;
    logic                  error_reg, error_next;

    logic                  accept;
    logic [16:0]           len_full;
    logic [16:0]           idx_inc;

    assign accept   = bus.rx_valid && rx_ready_reg;
    assign len_full = {1'b0, bus.rx_data, len_reg[7:0]};
    assign idx_inc  = 17'(idx_reg) + 17'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= LEN0;
            len_reg        <= '0;
            idx_reg        <= '0;
            byte_cnt_reg   <= '0;
            word_reg       <= '0;
            xor_reg        <= '0;
            rx_ready_reg   <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
            cpu_reset_reg  <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            idx_reg        <= idx_next;
            byte_cnt_reg   <= byte_cnt_next;
            word_reg       <= word_next;
            xor_reg        <= xor_next;
            rx_ready_reg   <= rx_ready_next;
            imem_we_reg    <= imem_we_next;
            imem_addr_reg  <= imem_addr_next;
            imem_wdata_reg <= imem_wdata_next;
            cpu_reset_reg  <= cpu_reset_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        idx_next        = idx_reg;
        byte_cnt_next   = byte_cnt_reg;
        word_next       = word_reg;
        xor_next        = xor_reg;
        imem_addr_next  = imem_addr_reg;
        imem_wdata_next = imem_wdata_reg;

        case (state_reg)
            LEN0: if (accept) begin
                len_next[7:0] = bus.rx_data;
                xor_next      = xor_reg ^ bus.rx_data;
                state_next    = LEN1;
            end
            LEN1: if (accept) begin
                len_next[15:8] = bus.rx_data;
                xor_next       = xor_reg ^ bus.rx_data;
                if (len_full > CAPACITY)  state_next = ERR;
                else if (len_full == 17'd0) state_next = CSUM;
                else                      state_next = WORD;
            end
            WORD: if (accept) begin
                word_next[{byte_cnt_reg, 3'b000} +: 8] = bus.rx_data;
                xor_next      = xor_reg ^ bus.rx_data;
                byte_cnt_next = byte_cnt_reg + 2'd1;
                if (byte_cnt_reg == 2'd3) begin
                    // Latch the write now so imem_we and its address/data rise together.
                    imem_addr_next  = idx_reg[ADDR_WIDTH-1:0];
                    imem_wdata_next = {bus.rx_data, word_reg[23:0]};
                    state_next      = WRITE;
                end
            end
            WRITE: begin
                idx_next   = idx_reg + 1'b1;
                state_next = (idx_inc == {1'b0, len_reg}) ? CSUM : WORD;
            end
            CSUM: if (accept) begin
                state_next = (bus.rx_data == xor_reg) ? DONE : ERR;
            end
            DONE:    state_next = DONE;
            ERR:     state_next = ERR;
            default: state_next = ERR;
        endcase

        // Outputs are registered from the next state so they line up with it.
        rx_ready_next  = (state_next == LEN0) || (state_next == LEN1) ||
                         (state_next == WORD) || (state_next == CSUM);
        imem_we_next   = (state_next == WRITE);
        done_next      = (state_next == DONE);
        error_next     = (state_next == ERR);
        cpu_reset_next = (state_next != DONE);
    end

    assign bus.rx_ready   = rx_ready_reg;
    assign bus.imem_we    = imem_we_reg;
    assign bus.imem_addr  = imem_addr_reg;
    assign bus.imem_wdata = imem_wdata_reg;
    assign bus.cpu_reset  = cpu_reset_reg;
    assign bus.done       = done_reg;
    assign bus.error      = error_reg;
endmodule
